// File: rtl/store_issue_queue.sv
// Committed-store FIFO feeding the write buffer p0 port: dual-slot enqueue,
// single-store wr/ack drain with a one-cycle gap, and a 16-byte-line load probe.
module store_issue_queue #(
   parameter int DEPTH      = 8,
   parameter int IQ_ENTRIES = 8,
   parameter int RENTRIES   = 16,
   parameter int AMSB       = 63
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   c0_v_i,
   input  logic [IQ_ENTRIES-1:0]  c0_id_i,
   input  logic [RENTRIES-1:0]    c0_rid_i,
   input  logic [15:0]            c0_sel_i,
   input  logic                   c0_wrap_i,
   input  logic [AMSB:0]          c0_adr_i,
   input  logic [63:0]            c0_dat_i,
   input  logic                   c1_v_i,
   input  logic [IQ_ENTRIES-1:0]  c1_id_i,
   input  logic [RENTRIES-1:0]    c1_rid_i,
   input  logic [15:0]            c1_sel_i,
   input  logic                   c1_wrap_i,
   input  logic [AMSB:0]          c1_adr_i,
   input  logic [63:0]            c1_dat_i,
   input  logic                   flush_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   wr_o,
   output logic [IQ_ENTRIES-1:0]  id_o,
   output logic [RENTRIES-1:0]    rid_o,
   output logic [15:0]            sel_o,
   output logic                   wrap_o,
   output logic [AMSB:0]          adr_o,
   output logic [63:0]            dat_o,
   input  logic                   ack_i,
   input  logic [AMSB:0]          ld_adr_i,
   output logic                   ld_hit_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [IQ_ENTRIES-1:0] id;
      logic [RENTRIES-1:0]   rid;
      logic [15:0]           sel;
      logic                  wrap;
      logic [AMSB:0]         adr;
      logic [63:0]           dat;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

   entry_t           mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    rd_ptr, wr_ptr, rd_ptr_inc, wr_ptr_inc;
   logic [CW-1:0]    count;
   state_t           state, state_nxt;
   logic             load, pop, enq_ok;
   logic [1:0]       n_enq;
   logic [DEPTH-1:0] head_mask, set_mask;
   entry_t           c0_e, c1_e, head_q;

   assign c0_e = '{id: c0_id_i, rid: c0_rid_i, sel: c0_sel_i, wrap: c0_wrap_i,
                   adr: c0_adr_i, dat: c0_dat_i};
   assign c1_e = '{id: c1_id_i, rid: c1_rid_i, sel: c1_sel_i, wrap: c1_wrap_i,
                   adr: c1_adr_i, dat: c1_dat_i};

   assign rd_ptr_inc = rd_ptr + 1'b1;
   assign wr_ptr_inc = wr_ptr + 1'b1;
   assign head_mask  = {{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr;

   // A flush cycle or a full queue discards whatever the commit stage offers.
   assign enq_ok = !flush_i && !full_o;
   assign n_enq  = enq_ok ? ({1'b0, c0_v_i} + {1'b0, c1_v_i}) : 2'd0;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
      set_mask = '0;
      if (n_enq == 2'd2)
         set_mask = ({{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr) | ({{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr_inc);
      else if (n_enq == 2'd1)
         set_mask = {{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      pop       = 1'b0;
      unique case (state)
         IDLE: if (count != '0 && !flush_i) begin
            load      = 1'b1;
            state_nxt = REQ;
         end
         REQ: if (ack_i) begin
            pop       = 1'b1;
            state_nxt = GAP;
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_i) begin
         state  <= IDLE;
         wr_o   <= 1'b0;
         head_q <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            wr_o   <= 1'b1;
            head_q <= mem[rd_ptr];
         end else if (pop) begin
            wr_o <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else if (flush_i) begin
         // The presented head survives a flush unless it is acked in the same cycle.
         if (state == REQ && !pop) begin
            vld    <= head_mask;
            count  <= CW'(1);
            wr_ptr <= rd_ptr_inc;
         end else if (pop) begin
            vld    <= '0;
            count  <= '0;
            rd_ptr <= rd_ptr_inc;
            wr_ptr <= rd_ptr_inc;
         end else begin
            vld    <= '0;
            count  <= '0;
            wr_ptr <= rd_ptr;
         end
      end else begin
         vld    <= (vld & ~(pop ? head_mask : '0)) | set_mask;
         count  <= count + CW'(n_enq) - CW'(pop);
         wr_ptr <= wr_ptr + PW'(n_enq);
         if (pop) rd_ptr <= rd_ptr_inc;
      end
   end

   // NOTE: the entry storage has no reset; the valid bits alone decide which contents mean anything.
   always_ff @(posedge clk_i) begin
      if (enq_ok) begin
         if (c0_v_i) begin
            mem[wr_ptr] <= c0_e;
            if (c1_v_i) mem[wr_ptr_inc] <= c1_e;
         end else if (c1_v_i) begin
            mem[wr_ptr] <= c1_e;
         end
      end
   end

   always_comb begin
      ld_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i] && ((mem[i].adr ^ ld_adr_i) >> 4) == '0) ld_hit_o = 1'b1;
   end

   assign full_o  = (count >= CW'(DEPTH - 1));
   assign empty_o = (count == '0) && (state == IDLE);
   assign count_o = count;
   assign id_o    = head_q.id;
   assign rid_o   = head_q.rid;
   assign sel_o   = head_q.sel;
   assign wrap_o  = head_q.wrap;
   assign adr_o   = head_q.adr;
   assign dat_o   = head_q.dat;

   enq_while_full_a: assert property (@(posedge clk_i) disable iff (!rst_i)
      full_o |-> !(c0_v_i || c1_v_i));

endmodule
